// File: rtl/chaos_step_sequencer.sv
// Avalon-MM controlled step sequencer for the chaos datapath: issues step strobes,
// waits for completion with a timeout, and spaces steps by a programmable gap.
module chaos_step_sequencer #(
   parameter int unsigned ACK_TIMEOUT = 1024
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [2:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        step_out,
   input  logic        step_done,
   output logic        irq
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_ISSUE    = 2'd1,
      S_WAIT_ACK = 2'd2,
      S_GAP      = 2'd3
   } state_t;

   localparam logic [15:0] TO_LAST = 16'(ACK_TIMEOUT - 32'd1);

   state_t      r_state;
   state_t      w_next;
   logic        r_cont;
   logic        r_irq_en;
   logic [31:0] r_count;
   logic [15:0] r_period;
   logic        r_done;
   logic        r_err;
   logic [31:0] r_steps_done;
   logic [31:0] r_remaining;
   logic [15:0] r_to_cnt;
   logic [15:0] r_gap_cnt;
   logic        r_stop_pend;
   logic        r_step_out;

   logic w_wr;
   logic w_ctrl_wr;
   logic w_start;
   logic w_stop;
   logic w_go;
   logic w_empty;
   logic w_ack;
   logic w_set_done;
   logic w_set_err;
   logic w_enter_gap;
   logic w_stat_wr;

   assign w_wr      = chipselect && !write_n;
   assign w_ctrl_wr = w_wr && (address == 3'd0);
   assign w_stat_wr = w_wr && (address == 3'd3);
   // STOP has priority: a combined START+STOP write never starts a sequence
   assign w_start   = w_ctrl_wr && writedata[0] && !writedata[1];
   assign w_stop    = w_ctrl_wr && writedata[1];

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state decode and per-cycle control strobes
   always_comb begin
      w_next      = r_state;
      w_go        = 1'b0;
      w_empty     = 1'b0;
      w_ack       = 1'b0;
      w_set_done  = 1'b0;
      w_set_err   = 1'b0;
      w_enter_gap = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_start) begin
               // CONT comes from the same write so START|CONT runs continuously
               if ((r_count == 32'd0) && !writedata[2]) begin
                  w_empty    = 1'b1;
                  w_set_done = 1'b1;
               end else begin
                  w_go   = 1'b1;
                  w_next = S_ISSUE;
               end
            end else begin
               w_next = S_IDLE;
            end
         end
         S_ISSUE: begin
            if (w_stop) begin
               w_next     = S_IDLE;
               w_set_done = 1'b1;
            end else begin
               w_next = S_WAIT_ACK;
            end
         end
         S_WAIT_ACK: begin
            if (step_done) begin
               w_ack = 1'b1;
               if ((!r_cont && (r_remaining <= 32'd1)) || r_stop_pend || w_stop) begin
                  w_next     = S_IDLE;
                  w_set_done = 1'b1;
               end else if (r_period == 16'd0) begin
                  w_next = S_ISSUE;
               end else begin
                  w_next      = S_GAP;
                  w_enter_gap = 1'b1;
               end
            end else if (r_to_cnt == TO_LAST) begin
               w_next    = S_IDLE;
               w_set_err = 1'b1;
            end else begin
               w_next = S_WAIT_ACK;
            end
         end
         S_GAP: begin
            if (w_stop) begin
               w_next     = S_IDLE;
               w_set_done = 1'b1;
            end else if (r_gap_cnt <= 16'd1) begin
               w_next = S_ISSUE;
            end else begin
               w_next = S_GAP;
            end
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // Registers, status flags, step/timeout/gap counters and the step strobe
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cont       <= 1'b0;
         r_irq_en     <= 1'b0;
         r_count      <= 32'd0;
         r_period     <= 16'd0;
         r_done       <= 1'b0;
         r_err        <= 1'b0;
         r_steps_done <= 32'd0;
         r_remaining  <= 32'd0;
         r_to_cnt     <= 16'd0;
         r_gap_cnt    <= 16'd0;
         r_stop_pend  <= 1'b0;
         r_step_out   <= 1'b0;
      end else begin
         if (w_ctrl_wr) begin
            r_cont   <= writedata[2];
            r_irq_en <= writedata[3];
         end
         if (w_wr && (address == 3'd1)) begin
            r_count <= writedata;
         end
         if (w_wr && (address == 3'd2)) begin
            r_period <= writedata[15:0];
         end

         if (w_set_done) begin
            r_done <= 1'b1;
         end else if (w_go || (w_stat_wr && writedata[1])) begin
            r_done <= 1'b0;
         end

         if (w_set_err) begin
            r_err <= 1'b1;
         end else if (w_go || w_empty || (w_stat_wr && writedata[2])) begin
            r_err <= 1'b0;
         end

         if (w_go || w_empty) begin
            r_steps_done <= 32'd0;
         end else if (w_ack) begin
            r_steps_done <= r_steps_done + 32'd1;
         end

         if (w_go) begin
            r_remaining <= r_count;
         end else if (w_ack && !r_cont) begin
            r_remaining <= r_remaining - 32'd1;
         end

         // Cleared in every other state, so it always starts at 0 in WAIT_ACK
         if (r_state == S_WAIT_ACK) begin
            r_to_cnt <= r_to_cnt + 16'd1;
         end else begin
            r_to_cnt <= 16'd0;
         end

         if (w_enter_gap) begin
            r_gap_cnt <= r_period;
         end else if ((r_state == S_GAP) && (r_gap_cnt != 16'd0)) begin
            r_gap_cnt <= r_gap_cnt - 16'd1;
         end

         if (w_next == S_IDLE) begin
            r_stop_pend <= 1'b0;
         end else if ((r_state == S_WAIT_ACK) && w_stop) begin
            r_stop_pend <= 1'b1;
         end

         r_step_out <= (w_next == S_ISSUE);
      end
   end

   assign step_out = r_step_out;
   assign irq      = r_irq_en && (r_done || r_err);

   // Zero-wait-state read mux
   always_comb begin
      readdata = 32'd0;
      case (address)
         3'd0:    readdata = {28'd0, r_irq_en, r_cont, 2'b00};
         3'd1:    readdata = r_count;
         3'd2:    readdata = {16'd0, r_period};
         3'd3:    readdata = {29'd0, r_err, r_done, (r_state != S_IDLE)};
         3'd4:    readdata = r_steps_done;
         default: readdata = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_chaos_step_sequencer.sv
// Directed self-checking bench for chaos_step_sequencer (ACK_TIMEOUT=16).
module tb_chaos_step_sequencer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        step_out;
   logic        step_done;
   logic        irq;

   int errors = 0;
   int checks = 0;
   int cyc_n  = 0;
   int npulse;
   int pulses [0:15];
   logic [31:0] rv;

   chaos_step_sequencer #(.ACK_TIMEOUT(16)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .step_out   (step_out),
      .step_done  (step_done),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      cyc_n++;
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      cyc();
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = 32'd0;
   endtask

   task automatic rd(input logic [2:0] a, output logic [31:0] d);
      address = a;
      #1;
      d = readdata;
   endtask

   // Watch step_out for a bounded number of cycles, optionally acking each
   // step one cycle after its strobe.
   task automatic run(input int budget, input bit ack);
      bit pend;
      pend   = 1'b0;
      npulse = 0;
      for (int i = 0; i < budget; i++) begin
         if (step_out === 1'b1 && npulse < 16) begin
            pulses[npulse] = cyc_n;
            npulse++;
         end
         step_done = ack && pend;
         pend      = (step_out === 1'b1);
         cyc();
      end
      step_done = 1'b0;
   endtask

   task automatic basic_run(input string tag);
      wr(3'd1, 32'd3);
      wr(3'd2, 32'hFFFF_0002);
      rd(3'd2, rv); chk({tag, " period_rd"}, rv, 32'h0000_0002);
      wr(3'd0, 32'h1);
      chk({tag, " first_step"}, {31'd0, step_out}, 32'd1);
      run(30, 1'b1);
      chk({tag, " npulse"}, npulse, 32'd3);
      chk({tag, " gap1"}, pulses[1] - pulses[0], 32'd4);
      chk({tag, " gap2"}, pulses[2] - pulses[1], 32'd4);
      rd(3'd3, rv); chk({tag, " status"}, rv, 32'h2);
      rd(3'd4, rv); chk({tag, " steps_done"}, rv, 32'd3);
   endtask

   initial begin
      reset_n    = 1'b0;
      address    = 3'd0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = 32'd0;
      step_done  = 1'b0;
      cyc();
      for (int a = 0; a < 5; a++) begin
         rd(3'(a), rv); chk("reset_reg", rv, 32'd0);
         cyc();
      end
      chk("reset_step_out", {31'd0, step_out}, 32'd0);
      chk("reset_irq", {31'd0, irq}, 32'd0);
      reset_n = 1'b1;
      cyc();

      // Basic counted run with gaps
      basic_run("run3");
      chk("run3_irq_off", {31'd0, irq}, 32'd0);
      wr(3'd3, 32'h2);
      rd(3'd3, rv); chk("status_w1c", rv, 32'h0);

      // Unmapped addresses
      wr(3'd5, 32'hFFFF_FFFF);
      rd(3'd5, rv); chk("addr5", rv, 32'd0);
      rd(3'd7, rv); chk("addr7", rv, 32'd0);

      // COUNT=0 with CONT=0 completes immediately
      wr(3'd1, 32'd0);
      wr(3'd0, 32'h1);
      rd(3'd3, rv); chk("empty_status", rv, 32'h2);
      rd(3'd4, rv); chk("empty_steps", rv, 32'd0);
      run(5, 1'b1);
      chk("empty_npulse", npulse, 32'd0);

      // Ack timeout with IRQ enabled
      wr(3'd1, 32'd5);
      wr(3'd0, 32'h9);
      chk("to_first_step", {31'd0, step_out}, 32'd1);
      rd(3'd3, rv); chk("to_err_cleared", rv, 32'h1);
      run(16, 1'b0);
      chk("to_npulse", npulse, 32'd1);
      rd(3'd3, rv); chk("to_still_busy", rv, 32'h1);
      cyc();
      rd(3'd3, rv); chk("to_status", rv, 32'h4);
      chk("to_irq", {31'd0, irq}, 32'd1);
      rd(3'd4, rv); chk("to_steps", rv, 32'd0);
      rd(3'd0, rv); chk("ctrl_rd", rv, 32'h8);
      wr(3'd3, 32'h4);
      chk("to_irq_clr", {31'd0, irq}, 32'd0);

      // Continuous mode, STOP during WAIT_ACK
      wr(3'd2, 32'd0);
      wr(3'd0, 32'h5);
      chk("cont_step1", {31'd0, step_out}, 32'd1);
      cyc();
      step_done = 1'b1;
      cyc();
      step_done = 1'b0;
      chk("cont_step2", {31'd0, step_out}, 32'd1);
      cyc();
      wr(3'd0, 32'h6);
      rd(3'd3, rv); chk("stop_pend_busy", rv, 32'h1);
      rd(3'd4, rv); chk("stop_pend_steps", rv, 32'd1);
      step_done = 1'b1;
      cyc();
      step_done = 1'b0;
      rd(3'd3, rv); chk("stop_status", rv, 32'h2);
      rd(3'd4, rv); chk("stop_steps", rv, 32'd2);
      run(10, 1'b1);
      chk("stop_npulse", npulse, 32'd0);

      // START+STOP together, then START while busy
      wr(3'd3, 32'h6);
      wr(3'd1, 32'd3);
      wr(3'd2, 32'd2);
      wr(3'd0, 32'h3);
      rd(3'd3, rv); chk("ss_status", rv, 32'h0);
      chk("ss_step_out", {31'd0, step_out}, 32'd0);
      rd(3'd4, rv); chk("ss_steps", rv, 32'd2);
      wr(3'd0, 32'h1);
      chk("busy_step1", {31'd0, step_out}, 32'd1);
      cyc();
      step_done = 1'b1;
      cyc();
      step_done = 1'b0;
      wr(3'd0, 32'h1);
      rd(3'd4, rv); chk("busy_start_steps", rv, 32'd1);
      run(30, 1'b1);
      chk("busy_npulse", npulse, 32'd2);
      chk("busy_gap", pulses[1] - pulses[0], 32'd4);
      rd(3'd3, rv); chk("busy_status", rv, 32'h2);
      rd(3'd4, rv); chk("busy_steps", rv, 32'd3);

      // Reset asserted during GAP of a long run
      wr(3'd1, 32'd10);
      wr(3'd0, 32'h9);
      cyc();
      step_done = 1'b1;
      cyc();
      step_done = 1'b0;
      reset_n = 1'b0;
      #1;
      chk("rst_mid_step_out", {31'd0, step_out}, 32'd0);
      for (int a = 0; a < 8; a++) begin
         rd(3'(a), rv); chk("rst_mid_reg", rv, 32'd0);
         cyc();
      end
      chk("rst_mid_irq", {31'd0, irq}, 32'd0);
      reset_n = 1'b1;
      run(10, 1'b1);
      chk("rst_mid_npulse", npulse, 32'd0);
      basic_run("rerun");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/chaos_step_sequencer.md
CHAOS_STEP_SEQUENCER -- requirements
Module: chaos_step_sequencer

Interface
REQ-001 Parameter ACK_TIMEOUT, default 1024, is the number of cycles to wait for step_done before an error is flagged (range 2..65535).
REQ-002 clk  input  1  the single clock; all state changes occur on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 address  input  3  Avalon-MM register word address.
REQ-005 chipselect  input  1  Avalon-MM select.
REQ-006 write_n  input  1  active-low write strobe; a write is chipselect && ~write_n.
REQ-007 writedata  input  32  write data.
REQ-008 readdata  output  32  combinational read data for the addressed register, zero wait states, unused bits 0.
REQ-009 step_out  output  1  one-cycle step strobe to the chaos datapath.
REQ-010 step_done  input  1  datapath completion pulse, one cycle per step.
REQ-011 irq  output  1  level interrupt.

Function
REQ-012 The register map SHALL be: 0 CTRL, 1 COUNT[31:0], 2 PERIOD[15:0], 3 STATUS, 4 STEPS_DONE[31:0] (read-only); addresses 5-7 SHALL read 0 and ignore writes.
REQ-013 CTRL SHALL have these bits: bit0 START (write-1 pulse, reads 0), bit1 STOP (write-1 pulse, reads 0), bit2 CONT (stored), bit3 IRQ_EN (stored).
REQ-014 STATUS SHALL have these bits: bit0 BUSY (state != IDLE), bit1 DONE, bit2 ERR; writing 1 to bit1 or bit2 SHALL clear that bit.
REQ-015 The FSM SHALL have the states IDLE, ISSUE, WAIT_ACK and GAP; BUSY = state != IDLE.
REQ-016 IDLE: on a START write, remaining SHALL load COUNT, STEPS_DONE SHALL clear, DONE and ERR SHALL clear, and the next state SHALL be ISSUE.
REQ-017 A START write with COUNT=0 and CONT=0 SHALL stay in IDLE and set DONE on the same edge.
REQ-018 START writes while BUSY SHALL be ignored.
REQ-019 A write with START=1 and STOP=1 together SHALL be treated as STOP only.
REQ-020 ISSUE SHALL last exactly one cycle, with step_out=1 only in this state; the next state SHALL be WAIT_ACK with the timeout counter cleared.
REQ-021 WAIT_ACK on step_done: STEPS_DONE SHALL increment (wrapping at 2^32), and remaining SHALL decrement if CONT=0.
REQ-022 From WAIT_ACK on step_done, the next state SHALL be IDLE with DONE set if remaining reaches 0 (CONT=0) or a STOP is pending; otherwise GAP.
REQ-023 WAIT_ACK SHALL ignore step_done pulses arriving in any other state.
REQ-024 WAIT_ACK timeout: if the counter reaches ACK_TIMEOUT-1 without step_done, ERR SHALL be set, DONE SHALL NOT be set, and the next state SHALL be IDLE.
REQ-025 GAP SHALL load its down-counter with PERIOD on entry and return to ISSUE when the counter reaches 0 (PERIOD=N gives N GAP cycles); PERIOD=0 SHALL go WAIT_ACK -> ISSUE directly.
REQ-026 A STOP write in ISSUE or GAP SHALL go to IDLE on the next edge and set DONE; a step already strobed SHALL still be counted only if step_done arrives in WAIT_ACK.
REQ-027 A STOP write in WAIT_ACK SHALL set a stop-pending flag; the current step completes or times out, and the flag SHALL clear on entry to IDLE.
REQ-028 COUNT and PERIOD writes SHALL take effect immediately in their registers; COUNT is sampled only at START and PERIOD only at GAP entry.
REQ-029 Step throughput SHALL be: START edge -> step_out high in the next cycle; step_done at cycle k -> next step_out at cycle k+PERIOD+1.
REQ-030 The irq output SHALL be IRQ_EN && (DONE || ERR).

Reset
REQ-031 While reset_n is low, the block SHALL be in state IDLE with step_out=0 and irq=0.
REQ-032 While reset_n is low, CTRL, COUNT, PERIOD, STATUS, STEPS_DONE, remaining, the counters and stop-pending SHALL all be 0.
REQ-033 Reset asserted mid-sequence SHALL abort the sequence immediately, with no further step_out after release until a new START.

Verification
REQ-034 Run scenario: COUNT=3, PERIOD=2, step_done 1 cycle after each step_out, START -> exactly 3 step_out pulses, each 4 cycles after the previous one, then DONE=1, BUSY=0, STEPS_DONE=3.
REQ-035 Run scenario: COUNT=0, CONT=0, START -> no step_out, DONE=1 after one edge, STEPS_DONE=0.
REQ-036 Run scenario: ACK_TIMEOUT=16, COUNT=5, step_done never asserted -> one step_out, ERR=1 16 cycles later, DONE=0, IRQ with IRQ_EN=1.
REQ-037 Run scenario: CONT=1, PERIOD=0, STOP written during WAIT_ACK, then step_done -> STEPS_DONE incremented once more, IDLE, DONE=1, no further step_out.
REQ-038 Run scenario: START+STOP in the same write, and START while BUSY -> no new sequence begins, and the running sequence is unaffected by the second START.
REQ-039 Run scenario: reset_n pulsed low during GAP of a COUNT=10 run -> all registers read 0, step_out stays 0, and a fresh START behaves as in REQ-034.
